// File: rtl/led_bank_arbiter.sv
// Round-robin arbiter sharing one VAL bus among NUM_REQ LED-bank requesters.
// A grant holds VAL/bank_sel for HOLD cycles, then pulses a one-cycle ack.
module led_bank_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int HOLD    = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       ack,
  output logic [WIDTH-1:0]         VAL,
  output logic [NUM_REQ-1:0]       bank_sel,
  output logic                     busy
);

  localparam int CW = $clog2(HOLD + 1);
  localparam int LW = $clog2(NUM_REQ);

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   val_q, val_d;
  logic [NUM_REQ-1:0] sel_q, sel_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               busy_q, busy_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [LW-1:0]      last_q, last_d;

  logic [NUM_REQ-1:0] elig;
  logic [LW-1:0]      cand;
  logic [LW-1:0]      gnt;
  logic               found;

  // The just-acked requester is masked so it drops to lowest priority.
  always_comb begin
    elig  = req & ~ack_q;
    found = 1'b0;
    gnt   = last_q;
    cand  = last_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = LW'((int'(last_q) + k) % NUM_REQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      val_q   <= '0;
      sel_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      last_q  <= LW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    val_d  = val_q;
    sel_d  = sel_q;
    ack_d  = '0;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    unique case (state_q)
      S_IDLE: begin
        sel_d  = '0;
        busy_d = 1'b0;
        if (found) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt == LW'(i)) begin
              val_d = req_data[i*WIDTH +: WIDTH];
            end
          end
          sel_d[gnt] = 1'b1;
          busy_d     = 1'b1;
          cnt_d      = CW'(HOLD - 1);
          last_d     = gnt;
        end
      end
      S_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          ack_d[last_q] = 1'b1;
          sel_d         = '0;
          busy_d        = 1'b0;
        end
      end
      default: begin
        sel_d  = '0;
        busy_d = 1'b0;
      end
    endcase
  end

  assign ack      = ack_q;
  assign VAL      = val_q;
  assign bank_sel = sel_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Bench for led_bank_arbiter: HOLD=8 and HOLD=1 instances share stimulus
// and are compared every cycle against a cycle-number based reference model.
module tb_led_bank_arbiter;
  localparam int N = 4;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;

  logic [N-1:0] ack0, sel0, ack1, sel1;
  logic [W-1:0] val0, val1;
  logic         busy0, busy1;

  always #5 clk = ~clk;

  led_bank_arbiter #(.NUM_REQ(N), .WIDTH(W), .HOLD(8)) u0 (
    .CLK(clk), .RST(rst), .req(req), .req_data(req_data),
    .ack(ack0), .VAL(val0), .bank_sel(sel0), .busy(busy0)
  );

  led_bank_arbiter #(.NUM_REQ(N), .WIDTH(W), .HOLD(1)) u1 (
    .CLK(clk), .RST(rst), .req(req), .req_data(req_data),
    .ack(ack1), .VAL(val1), .bank_sel(sel1), .busy(busy1)
  );

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  logic [W-1:0] m_val [2];
  logic [N-1:0] m_sel [2];
  logic [N-1:0] m_ack [2];
  logic         m_busy[2];
  int           m_last[2];
  int           m_g   [2];
  int           m_end [2];
  int           hold_of[2] = '{8, 1};

  int           gq[$];
  logic [W-1:0] vq[$];
  logic [N-1:0] prev_sel0 = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Grant at edge c ends with the ack edge at c+hold.
  task automatic model_tick(input int u);
    logic [N-1:0] elig;
    int g;
    bit found;
    if (rst) begin
      m_val[u]  = '0;
      m_sel[u]  = '0;
      m_ack[u]  = '0;
      m_busy[u] = 1'b0;
      m_last[u] = N - 1;
    end else if (m_busy[u]) begin
      m_ack[u] = '0;
      if (cyc == m_end[u]) begin
        m_sel[u]  = '0;
        m_busy[u] = 1'b0;
        m_ack[u]  = N'(1) << m_g[u];
      end
    end else begin
      elig     = req & ~m_ack[u];
      m_ack[u] = '0;
      found    = 1'b0;
      for (int k = 1; k <= N; k++) begin
        g = (m_last[u] + k) % N;
        if (!found && elig[g]) begin
          found  = 1'b1;
          m_g[u] = g;
        end
      end
      if (found) begin
        m_val[u]  = req_data[m_g[u]*W +: W];
        m_sel[u]  = N'(1) << m_g[u];
        m_busy[u] = 1'b1;
        m_last[u] = m_g[u];
        m_end[u]  = cyc + hold_of[u];
      end else begin
        m_sel[u] = '0;
      end
    end
  endtask

  task automatic compare_all();
    chk("val0", 32'(val0), 32'(m_val[0]));
    chk("sel0", 32'(sel0), 32'(m_sel[0]));
    chk("ack0", 32'(ack0), 32'(m_ack[0]));
    chk("busy0", 32'(busy0), 32'(m_busy[0]));
    chk("val1", 32'(val1), 32'(m_val[1]));
    chk("sel1", 32'(sel1), 32'(m_sel[1]));
    chk("ack1", 32'(ack1), 32'(m_ack[1]));
    chk("busy1", 32'(busy1), 32'(m_busy[1]));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_tick(0);
    model_tick(1);
    #1;
    compare_all();
    if (sel0 != '0 && prev_sel0 == '0) begin
      gq.push_back($clog2(sel0));
      vq.push_back(val0);
    end
    prev_sel0 = sel0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    step();
    rst = 1'b0;
    gq.delete();
    vq.delete();
  endtask

  int n;
  int gcyc;
  int acyc;
  int bad;
  bit seen;

  initial begin
    // single request
    do_reset();
    req      = 4'b0001;
    req_data = 16'h000A;
    n        = 0;
    seen     = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      if (sel0 == 4'b0001 && val0 == 4'hA) n++;
      if (ack0 == 4'b0001) begin
        seen = 1'b1;
        req  = '0;
      end
    end
    chk("t1_hold_len", n, 8);
    chk("t1_ack_seen", 32'(seen), 1);

    // all four at once
    do_reset();
    req      = 4'hF;
    req_data = 16'h4321;
    repeat (40) step();
    for (int i = 0; i < 4; i++) begin
      chk("t2_order", (i < gq.size()) ? gq[i] : -1, i);
      chk("t2_val", (i < vq.size()) ? 32'(vq[i]) : 32'hFFFF, i + 1);
    end

    // fairness between 0 and 2
    do_reset();
    req      = 4'b0101;
    req_data = 16'($urandom);
    repeat (60) step();
    for (int i = 0; i < 6; i++) begin
      chk("t3_alt", (i < gq.size()) ? gq[i] : -1, (i % 2) * 2);
    end

    // mid-hold data change and req drop
    do_reset();
    req      = 4'b0010;
    req_data = 16'h0030;
    step();
    gcyc = cyc;
    chk("t4_grant", 32'(sel0), 32'b0010);
    req_data = 16'h00C0;
    step();
    step();
    step();
    req  = '0;
    bad  = 0;
    seen = 1'b0;
    acyc = -1;
    for (int i = 0; i < 12 && !seen; i++) begin
      step();
      if (busy0 && val0 != 4'h3) bad++;
      if (ack0 == 4'b0010) begin
        seen = 1'b1;
        acyc = cyc;
      end
    end
    chk("t4_val_held", bad, 0);
    chk("t4_ack_delay", acyc - gcyc, 8);

    // reset during hold
    do_reset();
    req      = 4'b0100;
    req_data = 16'h0500;
    step();
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("t5_val", 32'(val0), 0);
    chk("t5_sel", 32'(sel0), 0);
    chk("t5_busy", 32'(busy0), 0);
    chk("t5_ack", 32'(ack0), 0);
    rst = 1'b0;
    req = 4'hF;
    step();
    chk("t5_first", 32'(sel0), 32'b0001);
    req = '0;
    repeat (12) step();

    // HOLD=1 instance
    do_reset();
    req = 4'b0011;
    step();
    chk("t6_sel_a", 32'(sel1), 32'b0001);
    chk("t6_ack_a", 32'(ack1), 0);
    step();
    chk("t6_sel_b", 32'(sel1), 0);
    chk("t6_ack_b", 32'(ack1), 32'b0001);
    step();
    chk("t6_sel_c", 32'(sel1), 32'b0010);
    chk("t6_ack_c", 32'(ack1), 0);
    step();
    chk("t6_sel_d", 32'(sel1), 0);
    chk("t6_ack_d", 32'(ack1), 32'b0010);
    req = '0;
    repeat (10) step();

    // random traffic
    do_reset();
    repeat (500) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      req_data = 16'($urandom);
      rst      = ($urandom_range(0, 59) == 0);
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
